// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: deserialises device-to-host frames into scancodes,
// buffers them in a FIFO and exposes them as a read-only peripheral (region 8'h21).
//
// Ports:
//   clk       system clock, all state on its rising edge
//   rst       asynchronous active-high reset
//   ps2_clk   raw PS/2 clock pin (asynchronous)
//   ps2_data  raw PS/2 data pin (asynchronous)
//   addr      bus byte address; addr[31:24] selects the block, addr[3:2] the register
//   rd        read strobe, qualifies addr for one cycle
//   data      read data, combinational from addr and state
//   irq       registered, high while the FIFO holds at least one scancode
//
// Register map: +0x0 DATA (FIFO head, read pops), +0x4 STATUS
//   STATUS = {16'h0, count[7:0], 3'b0, overflow, frame_err, parity_err, full, not_empty}
//   Reading STATUS clears the three sticky error bits.

module ps2_keyboard_rx #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic [31:0] addr,
    input  logic        rd,
    output logic [31:0] data,
    output logic        irq
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    // ------------------------------------------------------------------
    // Pin synchronisers; reset to 1 so the idle line does not look like
    // a falling edge when reset is released.
    // ------------------------------------------------------------------
    logic ps2c_s1_q;
    logic ps2c_s2_q;
    logic ps2c_s3_q;
    logic ps2d_s1_q;
    logic ps2d_s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps2c_s1_q <= 1'b1;
            ps2c_s2_q <= 1'b1;
            ps2c_s3_q <= 1'b1;
            ps2d_s1_q <= 1'b1;
            ps2d_s2_q <= 1'b1;
        end else begin
            ps2c_s1_q <= ps2_clk;
            ps2c_s2_q <= ps2c_s1_q;
            ps2c_s3_q <= ps2c_s2_q;
            ps2d_s1_q <= ps2_data;
            ps2d_s2_q <= ps2d_s1_q;
        end
    end

    logic ps2_fe;
    logic rx_bit;

    assign ps2_fe = ps2c_s3_q & ~ps2c_s2_q;
    assign rx_bit = ps2d_s2_q;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_e        state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [TW-1:0] tmo_q;

    logic timeout_hit;
    logic stop_fe;
    logic par_ok;
    logic frame_push;
    logic frame_bad_stop;
    logic frame_bad_par;

    // A falling edge in the same cycle counts as activity, so it wins
    // over a timeout that would otherwise fire on that cycle.
    assign timeout_hit = (state_q != ST_IDLE) && !ps2_fe
                         && (tmo_q == TMO_MAX);

    assign stop_fe        = (state_q == ST_STOP) && ps2_fe;
    assign par_ok         = ^{shift_q, par_q};
    assign frame_push     = stop_fe && rx_bit && par_ok;
    assign frame_bad_stop = stop_fe && !rx_bit;
    assign frame_bad_par  = stop_fe && rx_bit && !par_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            par_q     <= 1'b0;
            tmo_q     <= '0;
        end else begin
            if ((state_q == ST_IDLE) || ps2_fe) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + TW'(1);
            end

            if (timeout_hit) begin
                state_q <= ST_IDLE;
            end else if (ps2_fe) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (!rx_bit) begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        // Shift in at the MSB so the LSB-first stream
                        // lands in natural bit order after 8 bits.
                        shift_q   <= {rx_bit, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_q   <= rx_bit;
                        state_q <= ST_STOP;
                    end
                    ST_STOP: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic sel;
    logic sel_data;
    logic sel_stat;
    logic unused_addr_bits;

    assign sel      = (addr[31:24] == 8'h21);
    assign sel_data = sel && (addr[3:2] == 2'b00);
    assign sel_stat = sel && (addr[3:2] == 2'b01);
    assign unused_addr_bits = ^{addr[23:4], addr[1:0]};

    // ------------------------------------------------------------------
    // Scancode FIFO and sticky flags
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] rptr_q;
    logic [AW-1:0] rptr_d;
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] wptr_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          parity_err_q;
    logic          parity_err_d;
    logic          frame_err_q;
    logic          frame_err_d;
    logic          overflow_q;
    logic          overflow_d;
    logic          irq_q;
    logic          irq_d;

    logic empty;
    logic full;
    logic pop;
    logic push_ok;
    logic ovf_evt;
    logic stat_rd;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_FULL);
    assign pop     = rd && sel_data && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push_ok = frame_push && (!full || pop);
    assign ovf_evt = frame_push && full && !pop;
    assign stat_rd = rd && sel_stat;

    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        if (push_ok) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (push_ok && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!push_ok && pop) begin
            cnt_d = cnt_q - CW'(1);
        end

        // Set has priority over the clear-on-read.
        parity_err_d = (parity_err_q && !stat_rd) || frame_bad_par;
        frame_err_d  = (frame_err_q && !stat_rd)
                       || frame_bad_stop || timeout_hit;
        overflow_d   = (overflow_q && !stat_rd) || ovf_evt;

        irq_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr_q       <= '0;
            wptr_q       <= '0;
            cnt_q        <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            rptr_q       <= rptr_d;
            wptr_q       <= wptr_d;
            cnt_q        <= cnt_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overflow_q   <= overflow_d;
            irq_q        <= irq_d;
        end
    end

    // Storage needs no reset: a slot is only read after it was written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= shift_q;
        end
    end

    // ------------------------------------------------------------------
    // Read data
    // ------------------------------------------------------------------
    logic [7:0] cnt8;

    assign cnt8 = 8'(cnt_q);

    always_comb begin
        data = 32'h0;
        if (sel_data && !empty) begin
            data = {24'h0, mem_q[rptr_q]};
        end else if (sel_stat) begin
            data = {16'h0, cnt8, 3'b000, overflow_q, frame_err_q,
                    parity_err_q, full, !empty};
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Testbench for ps2_keyboard_rx: table vectors, directed corner sequences
// and randomized frames/reads checked against a queue-based model.

module tb_ps2_keyboard_rx;

    localparam int H     = 10;
    localparam int TMO   = 300;
    localparam int DEPTH = 8;

    localparam logic [31:0] A_DATA  = 32'h2100_0000;
    localparam logic [31:0] A_STAT  = 32'h2100_0004;
    localparam logic [31:0] A_OTHER = 32'h2100_0008;

    logic        clk = 1'b0;
    logic        rst;
    logic        ps2_clk;
    logic        ps2_data;
    logic [31:0] addr;
    logic        rd;
    logic [31:0] data;
    logic        irq;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ps2_keyboard_rx #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .addr     (addr),
        .rd       (rd),
        .data     (data),
        .irq      (irq)
    );

    typedef struct {
        logic [7:0]  b;
        logic        badp;
        logic        stopb;
        logic [31:0] exp_stat;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    // Reference model state
    logic [7:0] mq[$];
    logic       m_pe;
    logic       m_fe;
    logic       m_ov;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a;
        rd   = 1'b1;
        #1 d = data;
        @(negedge clk);
        rd   = 1'b0;
        addr = 32'h0;
    endtask

    task automatic ps2_bit(input logic v);
        ps2_data = v;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b,
                                             input logic badp,
                                             input logic stopb);
        logic p;
        p = ~(^b) ^ badp;
        return {stopb, p, b, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic badp,
                              input logic stopb);
        logic [10:0] f;
        f = mk_frame(b, badp, stopb);
        for (int i = 0; i < 11; i++) ps2_bit(f[i]);
        repeat (H) @(negedge clk);
    endtask

    // Sends a valid frame and pops DATA in exactly the cycle the stop
    // bit's falling edge is consumed (3 posedges after the pin falls).
    task automatic send_frame_pop(input logic [7:0] b,
                                  output logic [31:0] d);
        logic [10:0] f;
        f = mk_frame(b, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        @(negedge clk);
        @(negedge clk);
        addr = A_DATA;
        rd   = 1'b1;
        #1 d = data;
        @(negedge clk);
        rd   = 1'b0;
        addr = 32'h0;
        repeat (H - 3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    function automatic logic [31:0] m_status();
        logic [7:0] n;
        n = 8'(mq.size());
        return {16'h0, n, 3'b000, m_ov, m_fe, m_pe,
                mq.size() == DEPTH, mq.size() != 0};
    endfunction

    task automatic m_frame(input logic [7:0] b, input logic badp,
                           input logic stopb);
        if (!stopb) m_fe = 1'b1;
        else if (badp) m_pe = 1'b1;
        else if (mq.size() < DEPTH) mq.push_back(b);
        else m_ov = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rv;
        logic [31:0] pv;
        logic [7:0]  b;
        int          kind;
        int          op;

        vecs[0] = '{8'h1C, 1'b0, 1'b1, 32'h101, 32'h1C};
        vecs[1] = '{8'h1C, 1'b1, 1'b1, 32'h004, 32'h00};
        vecs[2] = '{8'h1C, 1'b0, 1'b0, 32'h008, 32'h00};
        vecs[3] = '{8'h1C, 1'b1, 1'b0, 32'h008, 32'h00};
        vecs[4] = '{8'hFF, 1'b0, 1'b1, 32'h101, 32'hFF};
        vecs[5] = '{8'h00, 1'b0, 1'b1, 32'h101, 32'h00};
        vecs[6] = '{8'hA5, 1'b1, 1'b1, 32'h004, 32'h00};
        vecs[7] = '{8'h80, 1'b0, 1'b1, 32'h101, 32'h80};

        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rd       = 1'b0;
        addr     = 32'h0;
        repeat (3) @(negedge clk);

        bus_read(A_DATA, rv);
        check("reset_data", rv, 32'h0);
        bus_read(A_STAT, rv);
        check("reset_status", rv, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        bus_read(A_STAT, rv);
        check("post_reset_status", rv, 32'h0);

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].b, vecs[i].badp, vecs[i].stopb);
            check($sformatf("vec%0d_irq", i), {31'h0, irq},
                  {31'h0, vecs[i].exp_stat[0]});
            bus_read(A_STAT, rv);
            check($sformatf("vec%0d_status", i), rv, vecs[i].exp_stat);
            bus_read(A_DATA, rv);
            check($sformatf("vec%0d_data", i), rv, vecs[i].exp_data);
            bus_read(A_STAT, rv);
            check($sformatf("vec%0d_status_after", i), rv, 32'h0);
            check($sformatf("vec%0d_irq_after", i), {31'h0, irq}, 32'h0);
        end

        // Overflow: 9 frames, no reads
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1);
        bus_read(A_OTHER, rv);
        check("other_addr", rv, 32'h0);
        bus_read(A_STAT, rv);
        check("ovf_status", rv, 32'h813);
        for (int i = 1; i <= 8; i++) begin
            bus_read(A_DATA, rv);
            check($sformatf("ovf_pop%0d", i), rv, 32'(i));
        end
        bus_read(A_STAT, rv);
        check("ovf_status_after", rv, 32'h0);

        // Timeout recovery
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        repeat (TMO + 10) @(negedge clk);
        send_frame(8'h5A, 1'b0, 1'b1);
        bus_read(A_STAT, rv);
        check("tmo_status", rv, 32'h109);
        bus_read(A_DATA, rv);
        check("tmo_data", rv, 32'h5A);

        // Concurrent pop and push, not full
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame_pop(8'h22, pv);
        check("cc_pop", pv, 32'h11);
        bus_read(A_STAT, rv);
        check("cc_status", rv, 32'h101);
        bus_read(A_DATA, rv);
        check("cc_next", rv, 32'h22);

        // Concurrent pop and push while full
        for (int i = 0; i < 8; i++) send_frame(8'h31 + 8'(i), 1'b0, 1'b1);
        send_frame_pop(8'h39, pv);
        check("ccf_pop", pv, 32'h31);
        bus_read(A_STAT, rv);
        check("ccf_status", rv, 32'h803);
        for (int i = 0; i < 8; i++) begin
            bus_read(A_DATA, rv);
            check($sformatf("ccf_pop%0d", i), rv, 32'h32 + 32'(i));
        end
        bus_read(A_STAT, rv);
        check("ccf_status_after", rv, 32'h0);

        // Reset mid-frame, with an entry already buffered
        send_frame(8'h77, 1'b0, 1'b1);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        @(negedge clk);
        rst      = 1'b1;
        ps2_data = 1'b1;
        addr     = A_DATA;
        #1 check("rst_mid_data", data, 32'h0);
        addr = A_STAT;
        #1 check("rst_mid_status", data, 32'h0);
        check("rst_mid_irq", {31'h0, irq}, 32'h0);
        addr = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send_frame(8'h29, 1'b0, 1'b1);
        bus_read(A_STAT, rv);
        check("rst_mid_after_status", rv, 32'h101);
        bus_read(A_DATA, rv);
        check("rst_mid_after_data", rv, 32'h29);
        bus_read(A_STAT, rv);
        check("rst_mid_after_empty", rv, 32'h0);

        // Randomized frames and reads against the model
        m_pe = 1'b0;
        m_fe = 1'b0;
        m_ov = 1'b0;
        for (int it = 0; it < 60; it++) begin
            op = int'($urandom_range(0, 9));
            if (op < 5) begin
                b    = 8'($urandom);
                kind = int'($urandom_range(0, 5));
                if (kind == 0) begin
                    send_frame(b, 1'b1, 1'b1);
                    m_frame(b, 1'b1, 1'b1);
                end else if (kind == 1) begin
                    pv = 32'($urandom_range(0, 1));
                    send_frame(b, pv[0], 1'b0);
                    m_frame(b, pv[0], 1'b0);
                end else begin
                    send_frame(b, 1'b0, 1'b1);
                    m_frame(b, 1'b0, 1'b1);
                end
            end else if (op < 8) begin
                bus_read(A_DATA, rv);
                if (mq.size() != 0) begin
                    check($sformatf("rnd%0d_data", it), rv,
                          {24'h0, mq[0]});
                    void'(mq.pop_front());
                end else begin
                    check($sformatf("rnd%0d_data_empty", it), rv, 32'h0);
                end
            end else begin
                bus_read(A_STAT, rv);
                check($sformatf("rnd%0d_status", it), rv, m_status());
                m_pe = 1'b0;
                m_fe = 1'b0;
                m_ov = 1'b0;
            end
            check($sformatf("rnd%0d_irq", it), {31'h0, irq},
                  {31'h0, mq.size() != 0});
        end
        bus_read(A_STAT, rv);
        check("rnd_final_status", rv, m_status());
        while (mq.size() != 0) begin
            bus_read(A_DATA, rv);
            check("rnd_drain", rv, {24'h0, mq[0]});
            void'(mq.pop_front());
        end
        bus_read(A_STAT, rv);
        check("rnd_drained", rv, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
